// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box table, state geometry and the
// scheduler's FSM / grant encodings.
package aes_pkg;

   localparam int unsigned NWORDS = 4;

   typedef enum logic [2:0] {
      IDLE,
      ST_RUN,
      ST_HOLD,
      KEY_RUN,
      KEY_HOLD
   } sched_state_t;

   typedef enum logic {
      STATE,
      KEY
   } grant_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/sbox_word.sv
// One 32-bit S-box lane: four independent forward byte substitutions.
module sbox_word
   import aes_pkg::*;
(
   input  logic [31:0] din,
   output logic [31:0] dout
);

   always_comb begin
      dout = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         dout[8*k +: 8] = SBOX[din[8*k +: 8]];
      end
   end

endmodule

// File: rtl/subbytes_sched.sv
// Shares one S-box lane between the round datapath (4 word passes per state)
// and key expansion (one SubWord), alternating grants under contention.
module subbytes_sched #(
   parameter int unsigned NWORDS    = 4,
   parameter bit          KEY_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  st_valid,
   output logic                  st_ready,
   input  logic [32*NWORDS-1:0]  st_in,
   output logic                  st_out_valid,
   input  logic                  st_out_ready,
   output logic [32*NWORDS-1:0]  st_out,
   input  logic                  key_valid,
   output logic                  key_ready,
   input  logic [31:0]           key_in,
   output logic                  key_out_valid,
   input  logic                  key_out_ready,
   output logic [31:0]           key_out,
   output logic                  busy
);

   localparam int unsigned CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   aes_pkg::sched_state_t state_q;
   aes_pkg::grant_t       last_q;
   logic [CW-1:0]         cnt_q;
   logic [32*NWORDS-1:0]  st_buf_q;
   logic [31:0]           key_buf_q;
   logic [32*NWORDS-1:0]  st_out_q;
   logic [31:0]           key_out_q;
   logic                  st_out_valid_q;
   logic                  key_out_valid_q;
   logic [31:0]           lane_in;
   logic [31:0]           lane_out;

   // Under contention the requester granted last backs off.
   always_comb begin
      st_ready  = !rst && (state_q == aes_pkg::IDLE) &&
                  !(key_valid && (last_q == aes_pkg::STATE));
      key_ready = !rst && (state_q == aes_pkg::IDLE) &&
                  !(st_valid && (last_q == aes_pkg::KEY));
   end

   always_comb begin
      lane_in = st_buf_q[32*cnt_q +: 32];
      if (state_q == aes_pkg::KEY_RUN) lane_in = key_buf_q;
   end

   sbox_word u_lane (
      .din  (lane_in),
      .dout (lane_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= aes_pkg::IDLE;
         last_q          <= KEY_FIRST ? aes_pkg::STATE : aes_pkg::KEY;
         cnt_q           <= '0;
         st_buf_q        <= '0;
         key_buf_q       <= '0;
         st_out_q        <= '0;
         key_out_q       <= '0;
         st_out_valid_q  <= 1'b0;
         key_out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            aes_pkg::IDLE: begin
               if (st_valid && st_ready) begin
                  st_buf_q <= st_in;
                  cnt_q    <= '0;
                  last_q   <= aes_pkg::STATE;
                  state_q  <= aes_pkg::ST_RUN;
               end else if (key_valid && key_ready) begin
                  key_buf_q <= key_in;
                  last_q    <= aes_pkg::KEY;
                  state_q   <= aes_pkg::KEY_RUN;
               end
            end
            aes_pkg::ST_RUN: begin
               st_out_q[32*cnt_q +: 32] <= lane_out;
               if (cnt_q == CW'(NWORDS-1)) begin
                  cnt_q          <= '0;
                  st_out_valid_q <= 1'b1;
                  state_q        <= aes_pkg::ST_HOLD;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            aes_pkg::ST_HOLD: begin
               if (st_out_ready) begin
                  st_out_valid_q <= 1'b0;
                  state_q        <= aes_pkg::IDLE;
               end
            end
            aes_pkg::KEY_RUN: begin
               key_out_q       <= lane_out;
               key_out_valid_q <= 1'b1;
               state_q         <= aes_pkg::KEY_HOLD;
            end
            aes_pkg::KEY_HOLD: begin
               if (key_out_ready) begin
                  key_out_valid_q <= 1'b0;
                  state_q         <= aes_pkg::IDLE;
               end
            end
            default: state_q <= aes_pkg::IDLE;
         endcase
      end
   end

   assign st_out        = st_out_q;
   assign key_out       = key_out_q;
   assign st_out_valid  = st_out_valid_q;
   assign key_out_valid = key_out_valid_q;
   assign busy          = (state_q != aes_pkg::IDLE);

endmodule

// File: tb/tb_subbytes_sched.sv
// Directed bench for subbytes_sched: SubWord/SubBytes values, latency,
// alternating arbitration, backpressure hold and mid-run reset.
module tb_subbytes_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         st_valid, st_ready, st_out_valid, st_out_ready;
   logic [127:0] st_in, st_out;
   logic         key_valid, key_ready, key_out_valid, key_out_ready;
   logic [31:0]  key_in, key_out;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [127:0] ST_SEQ_IN  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
   localparam logic [127:0] ST_SEQ_OUT = 128'h76ABD7FE_2B670130_C56F6BF2_7B777C63;

   always #5 clk = ~clk;

   subbytes_sched #(.NWORDS(4), .KEY_FIRST(1'b1)) dut (
      .clk           (clk),
      .rst           (rst),
      .st_valid      (st_valid),
      .st_ready      (st_ready),
      .st_in         (st_in),
      .st_out_valid  (st_out_valid),
      .st_out_ready  (st_out_ready),
      .st_out        (st_out),
      .key_valid     (key_valid),
      .key_ready     (key_ready),
      .key_in        (key_in),
      .key_out_valid (key_out_valid),
      .key_out_ready (key_out_ready),
      .key_out       (key_out),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Issues one state, scrambles st_in after accept, checks latency and result.
   task automatic run_state(input string tag, input logic [127:0] din, input logic [127:0] exp);
      int lat;
      st_in = din; st_valid = 1'b1; st_out_ready = 1'b1;
      settle();
      check({tag, "_rdy"}, {127'd0, st_ready}, 128'd1);
      lat = 99;
      for (int c = 1; c <= 10; c++) begin
         step();
         st_valid = 1'b0;
         st_in = {$urandom, $urandom, $urandom, $urandom};
         settle();
         if (st_out_valid) begin
            lat = c;
            break;
         end
      end
      check({tag, "_lat"}, 128'(lat), 128'd5);
      check({tag, "_out"}, st_out, exp);
      step();
      settle();
      check({tag, "_vclr"}, {126'd0, st_out_valid, busy}, 128'd0);
      check({tag, "_keep"}, st_out, exp);
   endtask

   initial begin
      logic [1:0] exp_g;
      int         grants;
      logic       expect_key;

      rst = 1'b1;
      st_valid = 1'b1; key_valid = 1'b1;
      st_in = '0; key_in = '0;
      st_out_ready = 1'b1; key_out_ready = 1'b1;
      step();
      settle();
      check("rst_readies", {126'd0, st_ready, key_ready}, 128'd0);
      check("rst_outs", {st_out_valid, key_out_valid, busy}, 128'd0);
      check("rst_data", st_out | {96'd0, key_out}, 128'd0);
      st_valid = 1'b0; key_valid = 1'b0;
      rst = 1'b0;
      step();

      // SubWord: accept at T, result at T+2, busy over T+1..T+2.
      key_in = 32'h00010203; key_valid = 1'b1;
      settle();
      check("key_rdy", {127'd0, key_ready}, 128'd1);
      step();
      key_valid = 1'b0; key_in = 32'hDEADBEEF;
      settle();
      check("key_t1", {126'd0, busy, key_out_valid}, 128'b10);
      step();
      settle();
      check("key_t2", {126'd0, busy, key_out_valid}, 128'b11);
      check("key_val", {96'd0, key_out}, {96'd0, 32'h637C777B});
      step();
      settle();
      check("key_t3", {126'd0, busy, key_out_valid}, 128'b00);
      check("key_keep", {96'd0, key_out}, {96'd0, 32'h637C777B});

      run_state("st00", '0, {16{8'h63}});
      run_state("st53", {16{8'h53}}, {16{8'hED}});
      run_state("stFF", {16{8'hFF}}, {16{8'h16}});
      run_state("stseq", ST_SEQ_IN, ST_SEQ_OUT);

      // Both requesters held from reset: KEY, STATE, KEY, STATE ...
      do_reset();
      st_in = '0; key_in = 32'h53535353;
      st_valid = 1'b1; key_valid = 1'b1;
      grants = 0; expect_key = 1'b1;
      for (int c = 0; c < 40 && grants < 4; c++) begin
         settle();
         if (st_ready || key_ready) begin
            exp_g = expect_key ? 2'b01 : 2'b10;
            check("grant", {126'd0, st_ready, key_ready}, {126'd0, exp_g});
            grants++;
            expect_key = !expect_key;
         end
         step();
      end
      check("grant_cnt", 128'(grants), 128'd4);
      check("alt_key", {96'd0, key_out}, {96'd0, 32'hEDEDEDED});
      st_valid = 1'b0; key_valid = 1'b0;
      for (int c = 0; c < 10 && busy; c++) step();

      // Backpressure: result and blocked readies held for 10 cycles.
      do_reset();
      st_out_ready = 1'b0;
      st_in = {16{8'h53}}; st_valid = 1'b1;
      step();
      st_valid = 1'b0;
      for (int c = 0; c < 10 && !st_out_valid; c++) step();
      st_valid = 1'b1; key_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         settle();
         check("bp_valid", {127'd0, st_out_valid}, 128'd1);
         check("bp_data", st_out, {16{8'hED}});
         check("bp_rdy", {126'd0, st_ready, key_ready}, 128'd0);
         step();
      end
      st_valid = 1'b0; key_valid = 1'b0;
      st_out_ready = 1'b1;
      step();
      settle();
      check("bp_release", {126'd0, st_out_valid, busy}, 128'd0);

      // Reset during ST_RUN at cnt=2, then a clean re-issue.
      st_in = {16{8'hFF}}; st_valid = 1'b1;
      step();
      st_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      settle();
      check("mid_rst_outs", {st_out_valid, key_out_valid, busy}, 128'd0);
      check("mid_rst_data", st_out, 128'd0);
      step();
      run_state("rerun", ST_SEQ_IN, ST_SEQ_OUT);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
